// File: rtl/vertex_fetch_controller.sv
// vertex_fetch_controller
//
// Walks a run of index entries and turns each one into a fully resolved vertex.
// For every vertex the block does three things, one memory access at a time:
//   - presents an index address;
//   - splits the returned entry into position/normal/material IDs;
//   - presents those IDs and captures the returned attribute data.
// Vertices leave on a ready/valid stream. A trailing partial triangle is dropped.
//
// Ports:
//   clk_in, rst_in          clock, asynchronous active-low reset
//   start_in                pulse, begins a run when idle
//   base_in, count_in       first index address, requested vertex count
//   busy_out, done_out      run in progress / one-cycle end-of-run pulse
//   index_id_out            index memory address
//   index_data_in           [0]=position ID, [1]=normal ID, [2]=material ID
//   position_id_out, normal_id_out, material_id_out  attribute addresses
//   position_in, normal_in  attribute data, MEM_LATENCY cycles after address
//   material_in             material data, combinational from material_id_out
//   vertex_valid_out, vertex_ready_in  output stream handshake
//   position_out, normal_out, material_out  vertex payload
//   tri_end_out, last_out   third vertex of a triangle / final vertex of the run
//   stall_count_out         only with VERTEX_FETCH_STALL_COUNT_EN defined: cycles
//                           with valid high and ready low, saturating
module vertex_fetch_controller #(
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned ID_WIDTH    = 12
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          start_in,
  input  logic [ID_WIDTH-1:0]           base_in,
  input  logic [ID_WIDTH-1:0]           count_in,
  output logic                          busy_out,
  output logic                          done_out,
  output logic [ID_WIDTH-1:0]           index_id_out,
  input  logic [2:0][ID_WIDTH-1:0]      index_data_in,
  output logic [ID_WIDTH-1:0]           position_id_out,
  output logic [ID_WIDTH-1:0]           normal_id_out,
  output logic [ID_WIDTH-1:0]           material_id_out,
  input  logic [2:0][31:0]              position_in,
  input  logic [2:0][31:0]              normal_in,
  input  logic [2:0][31:0]              material_in,
  output logic                          vertex_valid_out,
  input  logic                          vertex_ready_in,
  output logic [2:0][31:0]              position_out,
  output logic [2:0][31:0]              normal_out,
  output logic [2:0][31:0]              material_out,
  output logic                          tri_end_out,
  output logic                          last_out
`ifdef VERTEX_FETCH_STALL_COUNT_EN
  ,
  output logic [31:0]                   stall_count_out
`endif
);

  localparam int unsigned WaitW = $clog2(MEM_LATENCY + 2);
  // Each wait state lasts MEM_LATENCY+1 cycles: counter runs 0..MEM_LATENCY.
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_LATENCY);

  typedef enum logic [2:0] {StIdle, StIdxWait, StAttrWait, StEmit, StDone} state_e;

  state_e              state;
  logic [WaitW-1:0]    wait_cnt;
  logic [ID_WIDTH-1:0] vtx_cnt;
  logic [ID_WIDTH-1:0] run_len;
  logic [1:0]          tri_phase;
  logic [ID_WIDTH-1:0] n_req;

  // Whole triangles only.
  assign n_req = count_in - (count_in % ID_WIDTH'(3));

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state            <= StIdle;
      wait_cnt         <= '0;
      vtx_cnt          <= '0;
      run_len          <= '0;
      tri_phase        <= '0;
      busy_out         <= 1'b0;
      done_out         <= 1'b0;
      index_id_out     <= '0;
      position_id_out  <= '0;
      normal_id_out    <= '0;
      material_id_out  <= '0;
      vertex_valid_out <= 1'b0;
      position_out     <= '0;
      normal_out       <= '0;
      material_out     <= '0;
      tri_end_out      <= 1'b0;
      last_out         <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (start_in) begin
            busy_out <= 1'b1;
            if (n_req == '0) begin
              state <= StDone;
            end else begin
              run_len      <= n_req;
              index_id_out <= base_in;
              vtx_cnt      <= '0;
              tri_phase    <= '0;
              wait_cnt     <= '0;
              state        <= StIdxWait;
            end
          end
        end
        StIdxWait: begin
          if (wait_cnt == WaitLast) begin
            position_id_out <= index_data_in[0];
            normal_id_out   <= index_data_in[1];
            material_id_out <= index_data_in[2];
            wait_cnt        <= '0;
            state           <= StAttrWait;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        StAttrWait: begin
          if (wait_cnt == WaitLast) begin
            position_out     <= position_in;
            normal_out       <= normal_in;
            material_out     <= material_in;
            vertex_valid_out <= 1'b1;
            tri_end_out      <= (tri_phase == 2'd2);
            last_out         <= (vtx_cnt == run_len - 1'b1);
            wait_cnt         <= '0;
            state            <= StEmit;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        StEmit: begin
          // Valid is high for the whole of this state; payload holds until ready.
          if (vertex_ready_in) begin
            vertex_valid_out <= 1'b0;
            tri_end_out      <= 1'b0;
            last_out         <= 1'b0;
            if (last_out) begin
              done_out <= 1'b1;
              busy_out <= 1'b0;
              state    <= StDone;
            end else begin
              vtx_cnt      <= vtx_cnt + 1'b1;
              tri_phase    <= (tri_phase == 2'd2) ? 2'd0 : tri_phase + 1'b1;
              index_id_out <= index_id_out + 1'b1;
              state        <= StIdxWait;
            end
          end
        end
        StDone: begin
          // Entered with done already raised after a real run; an empty run
          // arrives with done low and raises it here first.
          if (!done_out) begin
            done_out <= 1'b1;
            busy_out <= 1'b0;
          end else begin
            done_out <= 1'b0;
            state    <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

`ifdef VERTEX_FETCH_STALL_COUNT_EN
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      stall_count_out <= '0;
    end else if (state == StIdle && start_in) begin
      stall_count_out <= '0;
    end else if (vertex_valid_out && !vertex_ready_in && stall_count_out != '1) begin
      stall_count_out <= stall_count_out + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_vertex_fetch_controller.sv
// Directed bench for vertex_fetch_controller with small behavioural memories.
module tb_vertex_fetch_controller;

  typedef logic [2:0][11:0] idx_t;
  typedef logic [2:0][31:0] vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_in;
  logic [11:0] base_in;
  logic [11:0] count_in;
  logic        busy_out;
  logic        done_out;
  logic [11:0] index_id_out;
  idx_t        index_data_in;
  logic [11:0] position_id_out;
  logic [11:0] normal_id_out;
  logic [11:0] material_id_out;
  vec_t        position_in;
  vec_t        normal_in;
  vec_t        material_in;
  logic        vertex_valid_out;
  logic        vertex_ready_in;
  vec_t        position_out;
  vec_t        normal_out;
  vec_t        material_out;
  logic        tri_end_out;
  logic        last_out;
`ifdef VERTEX_FETCH_STALL_COUNT_EN
  logic [31:0] stall_count_out;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vertex_fetch_controller #(
    .MEM_LATENCY(2),
    .ID_WIDTH   (12)
  ) dut (
    .clk_in          (clk),
    .rst_in          (rst_n),
    .start_in        (start_in),
    .base_in         (base_in),
    .count_in        (count_in),
    .busy_out        (busy_out),
    .done_out        (done_out),
    .index_id_out    (index_id_out),
    .index_data_in   (index_data_in),
    .position_id_out (position_id_out),
    .normal_id_out   (normal_id_out),
    .material_id_out (material_id_out),
    .position_in     (position_in),
    .normal_in       (normal_in),
    .material_in     (material_in),
    .vertex_valid_out(vertex_valid_out),
    .vertex_ready_in (vertex_ready_in),
    .position_out    (position_out),
    .normal_out      (normal_out),
    .material_out    (material_out),
    .tri_end_out     (tri_end_out),
    .last_out        (last_out)
`ifdef VERTEX_FETCH_STALL_COUNT_EN
    ,
    .stall_count_out (stall_count_out)
`endif
  );

  // Memory contents.
  function automatic idx_t idx_entry(input logic [11:0] a);
    idx_t e;
    e[0] = a + 12'd100;
    e[1] = a + 12'd200;
    e[2] = a ^ 12'h005;
    return e;
  endfunction

  function automatic vec_t pos_data(input logic [11:0] p);
    vec_t d;
    for (int k = 0; k < 3; k++) d[k] = {16'hA000, 4'(k), p};
    return d;
  endfunction

  function automatic vec_t norm_data(input logic [11:0] p);
    vec_t d;
    for (int k = 0; k < 3; k++) d[k] = {16'hB000, 4'(k), p};
    return d;
  endfunction

  function automatic vec_t mat_data(input logic [2:0] m);
    vec_t d;
    for (int k = 0; k < 3; k++) d[k] = {16'hC000, 8'(k), 5'd0, m};
    return d;
  endfunction

  // Two-stage registered memories (latency 2); material table is combinational.
  idx_t ie1, ie2;
  vec_t p1, p2, n1, n2;
  always @(posedge clk) begin
    ie1 <= idx_entry(index_id_out);
    ie2 <= ie1;
    p1  <= pos_data(position_id_out);
    p2  <= p1;
    n1  <= norm_data(normal_id_out);
    n2  <= n1;
  end
  assign index_data_in = ie2;
  assign position_in   = p2;
  assign normal_in     = n2;
  assign material_in   = mat_data(material_id_out[2:0]);

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One run; vertex stall_v is held unready for stall_n cycles.
  task automatic do_run(input logic [11:0] base, input logic [11:0] cnt, input int stall_v,
                        input int stall_n, input bit alt_start);
    int           n;
    int           cyc;
    int           prev;
    int           waited;
    logic [11:0]  a;
    idx_t         e;
    logic         stable;
    logic [302:0] snap;
    n = int'(cnt) - int'(cnt) % 3;
    prev = 0;
    @(negedge clk);
    start_in = 1'b1;
    base_in  = base;
    count_in = cnt;
    @(negedge clk);
    start_in = 1'b0;
    cyc = 1;
    check_eq("busy_accept", busy_out, 1);
    if (alt_start) begin
      start_in = 1'b1;
      base_in  = 12'h555;
      count_in = 12'd9;
      @(negedge clk);
      cyc++;
      start_in = 1'b0;
    end
    for (int v = 0; v < n; v++) begin
      waited = 0;
      while (!vertex_valid_out && waited < 40) begin
        @(negedge clk);
        cyc++;
        waited++;
      end
      if (!vertex_valid_out) begin
        check_eq("valid_timeout", 0, 1);
        return;
      end
      a = base + 12'(v);
      e = idx_entry(a);
      if (v == 0) check_eq("first_valid_cycle", cyc, 7);
      else if (stall_n == 0) check_eq("vertex_period", cyc - prev, 7);
      prev = cyc;
      check_eq("index_addr", index_id_out, a);
      check_eq("position", position_out, pos_data(e[0]));
      check_eq("normal", normal_out, norm_data(e[1]));
      check_eq("material", material_out, mat_data(e[2][2:0]));
      check_eq("tri_end", tri_end_out, (v % 3 == 2));
      check_eq("last", last_out, (v == n - 1));
      if (v == stall_v) begin
        snap = {index_id_out, position_out, normal_out, material_out,
                tri_end_out, last_out, vertex_valid_out};
        vertex_ready_in = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < stall_n; i++) begin
          @(negedge clk);
          cyc++;
          if ({index_id_out, position_out, normal_out, material_out,
               tri_end_out, last_out, vertex_valid_out} !== snap) stable = 1'b0;
        end
        check_eq("stall_stable", stable, 1);
        vertex_ready_in = 1'b1;
      end
      @(negedge clk);
      cyc++;
      check_eq("valid_drop", vertex_valid_out, 0);
    end
    check_eq("done_pulse", done_out, 1);
    check_eq("busy_drop", busy_out, 0);
    @(negedge clk);
    check_eq("done_single", done_out, 0);
    check_eq("no_extra_valid", vertex_valid_out, 0);
  endtask

  initial begin
    rst_n           = 1'b0;
    start_in        = 1'b0;
    base_in         = '0;
    count_in        = '0;
    vertex_ready_in = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", busy_out, 0);
    check_eq("rst_done", done_out, 0);
    check_eq("rst_valid", vertex_valid_out, 0);
    check_eq("rst_ids", {index_id_out, position_id_out, normal_id_out, material_id_out}, 0);
    check_eq("rst_data", {position_out, tri_end_out, last_out}, 0);
    rst_n = 1'b1;

    // Empty run: done without memory traffic.
    @(negedge clk);
    start_in = 1'b1;
    base_in  = 12'h123;
    count_in = 12'd0;
    @(negedge clk);
    start_in = 1'b0;
    check_eq("empty_busy", busy_out, 1);
    check_eq("empty_done_early", done_out, 0);
    @(negedge clk);
    check_eq("empty_done", done_out, 1);
    check_eq("empty_busy_drop", busy_out, 0);
    check_eq("empty_no_valid", vertex_valid_out, 0);
    check_eq("empty_index", index_id_out, 12'h000);
    @(negedge clk);
    check_eq("empty_done_single", done_out, 0);

    do_run(12'h000, 12'd3, -1, 0, 1'b0);
    do_run(12'hFFE, 12'd6, -1, 0, 1'b0);
    do_run(12'h010, 12'd5, -1, 0, 1'b0);
    do_run(12'h030, 12'd6, 1, 10, 1'b0);
`ifdef VERTEX_FETCH_STALL_COUNT_EN
    check_eq("stall_count", stall_count_out, 10);
`endif
    do_run(12'h080, 12'd3, -1, 0, 1'b1);

    // Reset while attribute fetch is pending.
    @(negedge clk);
    start_in = 1'b1;
    base_in  = 12'h040;
    count_in = 12'd3;
    @(negedge clk);
    start_in = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("pre_rst_pos_id", position_id_out, 12'h040 + 12'd100);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", busy_out, 0);
    check_eq("midrst_ids", {index_id_out, position_id_out, normal_id_out, material_id_out}, 0);
    check_eq("midrst_valid", vertex_valid_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_run(12'h020, 12'd3, -1, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
